wb_regfile: RTL and testbench

Writeback-side consumer of the MEM/WB pipeline register outputs. It selects the writeback data, commits it to a 32-entry general-purpose register file, and serves the two ID-stage read ports with write-first bypass. It also keeps a committed-write counter for debug and performance visibility. It sits between the MEM/WB register and the ID stage and closes the pipeline loop.

---
 rtl/wb_regfile.sv | 44 ++++
 tb/tb_wb_regfile.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: writeback select, 32-entry flop register file with write-first bypass, commit counter
module wb_regfile #(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    alu_res_reg,
  input  logic [WIDTH-1:0]    read_data_reg,
  input  logic [REG_BITS-1:0] rd_reg,
  input  logic                mem_to_reg_reg,
  input  logic                reg_write_reg,
  input  logic [REG_BITS-1:0] rs_addr,
  input  logic [REG_BITS-1:0] rt_addr,
  output logic [WIDTH-1:0]    rs_data,
  output logic [WIDTH-1:0]    rt_data,
  output logic [WIDTH-1:0]    wb_data,
  output logic                wr_commit,
  output logic [CNT_W-1:0]    commit_count
);
  localparam int N = 2 ** REG_BITS;
  logic [WIDTH-1:0] regs_q [N];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             commit;
  always_comb begin
    wb_data   = mem_to_reg_reg ? read_data_reg : alu_res_reg;
    commit    = reg_write_reg && (rd_reg != '0) && rst_n;
    wr_commit = commit;
    rs_data   = (rs_addr == '0) ? '0 : (commit && rs_addr == rd_reg) ? wb_data : regs_q[rs_addr];
    rt_data   = (rt_addr == '0) ? '0 : (commit && rt_addr == rd_reg) ? wb_data : regs_q[rt_addr];
    cnt_d     = commit ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) regs_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      if (commit) regs_q[rd_reg] <= wb_data;
      cnt_q <= cnt_d;
    end
  end
  assign commit_count = cnt_q;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: scoreboard bench for wb_regfile, plus a 4-bit-counter instance for wrap
module tb_wb_regfile;
  logic        clk = 0, rst_n = 0;
  logic [31:0] alu_res_reg, read_data_reg;
  logic [4:0]  rd_reg, rs_addr, rt_addr;
  logic        mem_to_reg_reg, reg_write_reg;
  logic [31:0] rs_data, rt_data, wb_data, commit_count;
  logic        wr_commit;
  logic [31:0] w_rs, w_rt, w_wb;
  logic        w_commit;
  logic [3:0]  w_cnt;
  typedef struct { string n; logic [31:0] v; } exp_t;
  exp_t        sb[$];
  exp_t        e;
  logic [31:0] m [32];
  int          mcnt = 0, errs = 0, nchk = 0;

  wb_regfile d (.clk(clk), .rst_n(rst_n), .alu_res_reg(alu_res_reg), .read_data_reg(read_data_reg),
    .rd_reg(rd_reg), .mem_to_reg_reg(mem_to_reg_reg), .reg_write_reg(reg_write_reg),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .wb_data(wb_data), .wr_commit(wr_commit), .commit_count(commit_count));
  wb_regfile #(.CNT_W(4)) w (.clk(clk), .rst_n(rst_n), .alu_res_reg(alu_res_reg), .read_data_reg(read_data_reg),
    .rd_reg(rd_reg), .mem_to_reg_reg(mem_to_reg_reg), .reg_write_reg(reg_write_reg),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(w_rs), .rt_data(w_rt),
    .wb_data(w_wb), .wr_commit(w_commit), .commit_count(w_cnt));

  always #5 clk = ~clk;

  task automatic drive(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdd,
                       input logic m2r, input logic we);
    rd_reg = rd; alu_res_reg = alu; read_data_reg = rdd; mem_to_reg_reg = m2r; reg_write_reg = we;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reg_write_reg === 1'b1 && rd_reg != 0 && rst_n) begin
      m[rd_reg] = mem_to_reg_reg ? read_data_reg : alu_res_reg;
      mcnt++;
    end
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) m[i] = 0;
    mcnt = 0;
  endtask

  task automatic test_reset();
    clear_model();
    drive(5, 32'hCAFE0001, 0, 0, 1);
    rs_addr = 5; rt_addr = 0;
    #2;
    sb.push_back('{"rst_rs", 32'h0});
    sb.push_back('{"rst_cnt", 32'h0});
    sb.push_back('{"rst_commit", 32'h0});
    sb.push_back('{"rst_wb", 32'hCAFE0001});
    e = sb.pop_front(); nchk++; if (rs_data !== e.v) begin errs++; $display("FAIL %s got %h want %h", e.n, rs_data, e.v); end
    e = sb.pop_front(); nchk++; if (commit_count !== e.v) begin errs++; $display("FAIL %s got %h want %h", e.n, commit_count, e.v); end
    e = sb.pop_front(); nchk++; if ({31'b0, wr_commit} !== e.v) begin errs++; $display("FAIL %s got %h want %h", e.n, wr_commit, e.v); end
    e = sb.pop_front(); nchk++; if (wb_data !== e.v) begin errs++; $display("FAIL %s got %h want %h", e.n, wb_data, e.v); end
    @(negedge clk); rst_n = 1;
    drive(5, 32'hDEADBEEF, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    sb.push_back('{"pre_clear_r5", m[5]});
    e = sb.pop_front(); nchk++; if (rs_data !== e.v) begin errs++; $display("FAIL %s got %h want %h", e.n, rs_data, e.v); end
    @(negedge clk); rst_n = 0; clear_model();
    #1;
    sb.push_back('{"clear_r5", 32'h0});
    sb.push_back('{"clear_cnt", 32'h0});
    e = sb.pop_front(); nchk++; if (rs_data !== e.v) begin errs++; $display("FAIL %s got %h want %h", e.n, rs_data, e.v); end
    e = sb.pop_front(); nchk++; if (commit_count !== e.v) begin errs++; $display("FAIL %s got %h want %h", e.n, commit_count, e.v); end
    drive(5, 32'h12345678, 0, 0, 1);
    tick();
    #1;
    sb.push_back('{"rst_drop_r5", 32'h0});
    e = sb.pop_front(); nchk++; if (rs_data !== e.v) begin errs++; $display("FAIL %s got %h want %h", e.n, rs_data, e.v); end
    drive(0, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_write_select();
    @(negedge clk);
    drive(7, 32'h11111111, 32'h22222222, 0, 1);
    rs_addr = 7; rt_addr = 7;
    tick();
    reg_write_reg = 0;
    #1;
    sb.push_back('{"sel_alu_r7", 32'h11111111});
    e = sb.pop_front(); nchk++; if (rs_data !== e.v || m[7] !== e.v) begin errs++; $display("FAIL %s got %h want %h", e.n, rs_data, e.v); end
    drive(7, 32'h11111111, 32'h22222222, 1, 1);
    #1;
    sb.push_back('{"sel_mem_wb", 32'h22222222});
    e = sb.pop_front(); nchk++; if (wb_data !== e.v) begin errs++; $display("FAIL %s got %h want %h", e.n, wb_data, e.v); end
    tick();
    reg_write_reg = 0;
    #1;
    sb.push_back('{"sel_mem_r7", 32'h22222222});
    sb.push_back('{"sel_cnt", 32'd2});
    e = sb.pop_front(); nchk++; if (rt_data !== e.v) begin errs++; $display("FAIL %s got %h want %h", e.n, rt_data, e.v); end
    e = sb.pop_front(); nchk++; if (commit_count !== e.v) begin errs++; $display("FAIL %s got %h want %h", e.n, commit_count, e.v); end
  endtask

  task automatic test_r0();
    drive(0, 32'hFFFFFFFF, 32'h0, 0, 1);
    rs_addr = 0; rt_addr = 0;
    #1;
    sb.push_back('{"r0_commit", 32'h0});
    sb.push_back('{"r0_bypass", 32'h0});
    e = sb.pop_front(); nchk++; if ({31'b0, wr_commit} !== e.v) begin errs++; $display("FAIL %s got %h want %h", e.n, wr_commit, e.v); end
    e = sb.pop_front(); nchk++; if (rs_data !== e.v) begin errs++; $display("FAIL %s got %h want %h", e.n, rs_data, e.v); end
    tick();
    #1;
    sb.push_back('{"r0_read", 32'h0});
    sb.push_back('{"r0_cnt", mcnt});
    e = sb.pop_front(); nchk++; if (rt_data !== e.v) begin errs++; $display("FAIL %s got %h want %h", e.n, rt_data, e.v); end
    e = sb.pop_front(); nchk++; if (commit_count !== e.v) begin errs++; $display("FAIL %s got %h want %h", e.n, commit_count, e.v); end
    reg_write_reg = 0;
  endtask

  task automatic test_bypass();
    drive(3, 32'h00000010, 0, 0, 1);
    tick();
    drive(3, 32'h00000020, 0, 0, 1);
    rs_addr = 3; rt_addr = 3;
    #1;
    sb.push_back('{"byp_rs", 32'h20});
    sb.push_back('{"byp_rt", 32'h20});
    sb.push_back('{"byp_commit", 32'h1});
    e = sb.pop_front(); nchk++; if (rs_data !== e.v) begin errs++; $display("FAIL %s got %h want %h", e.n, rs_data, e.v); end
    e = sb.pop_front(); nchk++; if (rt_data !== e.v) begin errs++; $display("FAIL %s got %h want %h", e.n, rt_data, e.v); end
    e = sb.pop_front(); nchk++; if ({31'b0, wr_commit} !== e.v) begin errs++; $display("FAIL %s got %h want %h", e.n, wr_commit, e.v); end
    tick();
    reg_write_reg = 0;
    #1;
    sb.push_back('{"byp_stored", m[3]});
    e = sb.pop_front(); nchk++; if (rs_data !== e.v || e.v !== 32'h20) begin errs++; $display("FAIL %s got %h want %h", e.n, rs_data, e.v); end
  endtask

  task automatic test_disabled();
    drive(4, 32'h00000444, 0, 0, 1);
    tick();
    drive(4, 32'hABCDEF01, 32'hABCDEF01, 0, 0);
    rs_addr = 4; rt_addr = 4;
    #1;
    sb.push_back('{"dis_nobyp", 32'h444});
    e = sb.pop_front(); nchk++; if (rs_data !== e.v) begin errs++; $display("FAIL %s got %h want %h", e.n, rs_data, e.v); end
    tick();
    alu_res_reg = 'x; read_data_reg = 'x; mem_to_reg_reg = 'x;
    tick();
    #1;
    sb.push_back('{"dis_r4_kept", 32'h444});
    sb.push_back('{"dis_cnt", mcnt});
    e = sb.pop_front(); nchk++; if (rt_data !== e.v) begin errs++; $display("FAIL %s got %h want %h", e.n, rt_data, e.v); end
    e = sb.pop_front(); nchk++; if (commit_count !== e.v) begin errs++; $display("FAIL %s got %h want %h", e.n, commit_count, e.v); end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i < 32; i++) begin
      drive(i[4:0], $urandom, $urandom, 1'($urandom_range(0, 1)), 1);
      rs_addr = i[4:0] - 5'd1; rt_addr = i[4:0];
      #1;
      sb.push_back('{$sformatf("b2b_prev_r%0d", i - 1), m[i - 1]});
      sb.push_back('{$sformatf("b2b_byp_r%0d", i), mem_to_reg_reg ? read_data_reg : alu_res_reg});
      e = sb.pop_front(); nchk++; if (rs_data !== e.v) begin errs++; $display("FAIL %s got %h want %h", e.n, rs_data, e.v); end
      e = sb.pop_front(); nchk++; if (rt_data !== e.v) begin errs++; $display("FAIL %s got %h want %h", e.n, rt_data, e.v); end
      tick();
    end
    reg_write_reg = 0;
    for (int i = 0; i < 32; i++) begin
      rs_addr = i[4:0]; rt_addr = 5'(31 - i);
      #1;
      sb.push_back('{$sformatf("b2b_rd_r%0d", i), m[i]});
      e = sb.pop_front(); nchk++; if (rs_data !== e.v) begin errs++; $display("FAIL %s got %h want %h", e.n, rs_data, e.v); end
    end
    sb.push_back('{"b2b_cnt", mcnt});
    e = sb.pop_front(); nchk++; if (commit_count !== e.v) begin errs++; $display("FAIL %s got %h want %h", e.n, commit_count, e.v); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      drive(5'(1 + i % 31), 32'(i), 0, 0, 1);
      tick();
      sb.push_back('{$sformatf("wrap_cnt4_%0d", i), 32'(mcnt % 16)});
      sb.push_back('{$sformatf("wrap_cnt32_%0d", i), 32'(mcnt)});
      e = sb.pop_front(); nchk++; if ({28'b0, w_cnt} !== e.v) begin errs++; $display("FAIL %s got %h want %h", e.n, w_cnt, e.v); end
      e = sb.pop_front(); nchk++; if (commit_count !== e.v) begin errs++; $display("FAIL %s got %h want %h", e.n, commit_count, e.v); end
    end
    drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    rs_addr = 0; rt_addr = 0;
    drive(0, 0, 0, 0, 0);
    test_reset();
    test_write_select();
    test_r0();
    test_bypass();
    test_disabled();
    test_back_to_back();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
